break_value_pipeline: RTL and testbench

Sequential, parametrised break-value engine for the WalkSAT flip-selection path. It accepts one candidate variable's clause-broken vector per transaction over a valid/ready handshake. It masks the vector with the clause-table valid bits and popcounts it CHUNK_BITS clauses per cycle. It returns the break value with the candidate index and can optionally track the minimum-break candidate across a batch for the Heuristic_Selector.

---
 rtl/break_value_pipeline_if.sv | 38 +++
 rtl/break_value_pipeline.sv | 137 +++++++++++++
 tb/tb_break_value_pipeline.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/break_value_pipeline_if.sv
// Handshake and data bundle for break_value_pipeline.
// master = candidate producer / result consumer side, slave = the engine.
interface break_value_pipeline_if #(
    parameter int NUM_CLAUSES = 20,
    parameter int NUM_CANDS   = 4
);
    localparam int IDX_W = (NUM_CANDS > 1) ? $clog2(NUM_CANDS) : 1;
    localparam int BV_W  = $clog2(NUM_CLAUSES + 1);

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [NUM_CLAUSES-1:0] clause_broken_i;
    logic [NUM_CLAUSES-1:0] mask_bits_i;
    logic [IDX_W-1:0]       cand_idx_i;
    logic                   last_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [BV_W-1:0]        break_value_o;
    logic [IDX_W-1:0]       cand_idx_o;
    logic [NUM_CLAUSES-1:0] clause_broken_o;
    logic                   min_valid_o;
    logic [BV_W-1:0]        min_value_o;
    logic [IDX_W-1:0]       min_idx_o;

    modport master (
        output in_valid_i, clause_broken_i, mask_bits_i, cand_idx_i, last_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, break_value_o, cand_idx_o,
        input  clause_broken_o, min_valid_o, min_value_o, min_idx_o
    );

    modport slave (
        input  in_valid_i, clause_broken_i, mask_bits_i, cand_idx_i, last_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, break_value_o, cand_idx_o,
        output clause_broken_o, min_valid_o, min_value_o, min_idx_o
    );
endinterface

// File: rtl/break_value_pipeline.sv
// Chunked masked-popcount break-value engine for WalkSAT flip selection.
// Define BV_MIN_TRACK_EN to enable the per-batch minimum-break tracker.
module break_value_pipeline #(
    parameter int NUM_CLAUSES = 20,
    parameter int CHUNK_BITS  = 8,
    parameter int NUM_CANDS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    break_value_pipeline_if.slave bus
);
    localparam int IDX_W      = (NUM_CANDS > 1) ? $clog2(NUM_CANDS) : 1;
    localparam int BV_W       = $clog2(NUM_CLAUSES + 1);
    localparam int NUM_CHUNKS = (NUM_CLAUSES + CHUNK_BITS - 1) / CHUNK_BITS;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_BITS;
    localparam int CH_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CH_W-1:0] LAST_CHUNK = CH_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PAD_W-1:0]      r_vec;
    logic [BV_W-1:0]       r_acc;
    logic [CH_W-1:0]       r_chunk;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_hs;
    logic [CHUNK_BITS-1:0] w_slice;
    logic [BV_W-1:0]       w_pop;
    logic [PAD_W-1:0]      w_masked;

    assign w_in_ready = (r_state == IDLE) || (r_state == DONE && bus.out_ready_i);
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_hs       = (r_state == DONE) && bus.out_ready_i;
    // Zero-extended so the last chunk's padding bits always count as 0
    assign w_masked   = PAD_W'(bus.clause_broken_i & bus.mask_bits_i);
    assign w_slice    = r_vec[int'(r_chunk) * CHUNK_BITS +: CHUNK_BITS];

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK_BITS; i++) begin
            w_pop = w_pop + BV_W'(w_slice[i]);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = COUNT;
            COUNT:   if (r_chunk == LAST_CHUNK) w_next = DONE;
            DONE:    if (bus.out_ready_i) w_next = w_accept ? COUNT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_acc   <= '0;
            r_chunk <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_vec   <= w_masked;
                r_idx   <= bus.cand_idx_i;
                r_acc   <= '0;
                r_chunk <= '0;
            end else if (r_state == COUNT) begin
                r_acc   <= r_acc + w_pop;
                r_chunk <= r_chunk + CH_W'(1);
            end
        end
    end

    assign bus.in_ready_o      = w_in_ready;
    assign bus.out_valid_o     = (r_state == DONE);
    assign bus.break_value_o   = r_acc;
    assign bus.cand_idx_o      = r_idx;
    assign bus.clause_broken_o = r_vec[NUM_CLAUSES-1:0];

`ifdef BV_MIN_TRACK_EN
    logic             r_last;
    logic             r_first;
    logic [BV_W-1:0]  r_run_min;
    logic [IDX_W-1:0] r_run_idx;
    logic             r_min_valid;
    logic [BV_W-1:0]  r_min_value;
    logic [IDX_W-1:0] r_min_idx;
    logic             w_take;
    logic [BV_W-1:0]  w_new_min;
    logic [IDX_W-1:0] w_new_idx;

    // Strict less-than keeps the earlier candidate on ties
    assign w_take    = r_first || (r_acc < r_run_min);
    assign w_new_min = w_take ? r_acc : r_run_min;
    assign w_new_idx = w_take ? r_idx : r_run_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= 1'b0;
            r_first     <= 1'b1;
            r_run_min   <= '0;
            r_run_idx   <= '0;
            r_min_valid <= 1'b0;
            r_min_value <= '0;
            r_min_idx   <= '0;
        end else begin
            r_min_valid <= 1'b0;
            if (w_accept) r_last <= bus.last_i;
            if (w_hs) begin
                if (r_last) begin
                    r_min_value <= w_new_min;
                    r_min_idx   <= w_new_idx;
                    r_min_valid <= 1'b1;
                    r_first     <= 1'b1;
                end else begin
                    r_run_min   <= w_new_min;
                    r_run_idx   <= w_new_idx;
                    r_first     <= 1'b0;
                end
            end
        end
    end

    assign bus.min_valid_o = r_min_valid;
    assign bus.min_value_o = r_min_value;
    assign bus.min_idx_o   = r_min_idx;
`else
    assign bus.min_valid_o = 1'b0;
    assign bus.min_value_o = '0;
    assign bus.min_idx_o   = '0;
`endif
endmodule

// File: tb/tb_break_value_pipeline.sv
// Randomised self-checking bench for break_value_pipeline (default and 9/4 builds).
module tb_break_value_pipeline;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    break_value_pipeline_if #(.NUM_CLAUSES(20), .NUM_CANDS(4)) bus();
    break_value_pipeline #(.NUM_CLAUSES(20), .CHUNK_BITS(8), .NUM_CANDS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    break_value_pipeline_if #(.NUM_CLAUSES(9), .NUM_CANDS(4)) sbus();
    break_value_pipeline #(.NUM_CLAUSES(9), .CHUNK_BITS(4), .NUM_CANDS(4)) sdut (
        .clk(clk), .reset(reset), .bus(sbus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] ones_vec(input int k);
        logic [19:0] v;
        int sh;
        v  = '0;
        sh = $urandom_range(20 - k, 0);
        for (int i = 0; i < k; i++) v[sh + i] = 1'b1;
        return v;
    endfunction

    // Launches one transaction on the main DUT and returns what it produced.
    task automatic run_txn(input logic [19:0] br, input logic [19:0] mk,
                           input logic [1:0] idx, input logic lst,
                           output int lat, output logic [4:0] bv,
                           output logic [1:0] oi, output logic [19:0] ov,
                           output logic mv);
        bus.in_valid_i      = 1'b1;
        bus.clause_broken_i = br;
        bus.mask_bits_i     = mk;
        bus.cand_idx_i      = idx;
        bus.last_i          = lst;
        tick();
        bus.in_valid_i      = 1'b0;
        bus.clause_broken_i = 20'($urandom);
        bus.mask_bits_i     = 20'($urandom);
        bus.cand_idx_i      = 2'($urandom);
        bus.last_i          = 1'($urandom);
        lat = -1; bv = '0; oi = '0; ov = '0; mv = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.out_valid_o) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            bv = bus.break_value_o;
            oi = bus.cand_idx_o;
            ov = bus.clause_broken_o;
            tick();
            mv = bus.min_valid_o;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0h want 0", bus.out_valid_o); end
        n_cmp++;
        if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0h want 1", bus.in_ready_o); end
        n_cmp++;
        if (bus.break_value_o !== 5'd0) begin n_bad++; $display("FAIL reset_bv got %0h want 0", bus.break_value_o); end
        n_cmp++;
        if (bus.cand_idx_o !== 2'd0) begin n_bad++; $display("FAIL reset_idx got %0h want 0", bus.cand_idx_o); end
        n_cmp++;
        if (bus.clause_broken_o !== 20'd0) begin n_bad++; $display("FAIL reset_vec got %0h want 0", bus.clause_broken_o); end
        n_cmp++;
        if ({bus.min_valid_o, bus.min_value_o, bus.min_idx_o} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_min got %0h/%0h/%0h want 0/0/0", bus.min_valid_o, bus.min_value_o, bus.min_idx_o);
        end
        n_cmp++;
        if (sbus.out_valid_o !== 1'b0 || sbus.break_value_o !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_small got %0h/%0h want 0/0", sbus.out_valid_o, sbus.break_value_o);
        end
        n_cmp++;
        reset = 1'b0;
    endtask

    task automatic test_all_broken();
        int lat; logic [4:0] bv; logic [1:0] oi; logic [19:0] ov; logic mv;
        run_txn(20'hFFFFF, 20'hFFFFF, 2'd2, 1'b0, lat, bv, oi, ov, mv);
        if (lat !== 3) begin n_bad++; $display("FAIL allb_latency got %0d want 3", lat); end
        n_cmp++;
        if (bv !== 5'd20) begin n_bad++; $display("FAIL allb_bv got %0d want 20", bv); end
        n_cmp++;
        if (ov !== 20'hFFFFF) begin n_bad++; $display("FAIL allb_vec got %0h want fffff", ov); end
        n_cmp++;
        if (oi !== 2'd2) begin n_bad++; $display("FAIL allb_idx got %0d want 2", oi); end
        n_cmp++;
    endtask

    task automatic test_masked();
        int lat; logic [4:0] bv; logic [1:0] oi; logic [19:0] ov; logic mv;
        run_txn(20'hF0F0F, 20'h0FFFF, 2'd1, 1'b0, lat, bv, oi, ov, mv);
        if (bv !== 5'd8) begin n_bad++; $display("FAIL masked_bv got %0d want 8", bv); end
        n_cmp++;
        if (ov !== 20'h00F0F) begin n_bad++; $display("FAIL masked_vec got %0h want 00f0f", ov); end
        n_cmp++;
        if (oi !== 2'd1) begin n_bad++; $display("FAIL masked_idx got %0d want 1", oi); end
        n_cmp++;
    endtask

    task automatic test_random();
        int lat; logic [4:0] bv; logic [1:0] oi; logic [19:0] ov; logic mv;
        logic [19:0] br, mk; logic [1:0] idx;
        for (int t = 0; t < 24; t++) begin
            br  = 20'($urandom);
            mk  = 20'($urandom);
            idx = 2'($urandom);
            run_txn(br, mk, idx, 1'($urandom), lat, bv, oi, ov, mv);
            if (lat !== 3 || bv !== 5'($countones(br & mk))) begin
                n_bad++;
                $display("FAIL rand_bv[%0d] got %0d lat %0d want %0d lat 3", t, bv, lat, $countones(br & mk));
            end
            n_cmp++;
            if (ov !== (br & mk) || oi !== idx) begin
                n_bad++;
                $display("FAIL rand_vec[%0d] got %0h/%0d want %0h/%0d", t, ov, oi, br & mk, idx);
            end
            n_cmp++;
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] a_br, a_mk, b_br, b_mk;
        logic [4:0]  bv0;
        logic [19:0] ov0;
        int lat;
        a_br = 20'($urandom); a_mk = 20'($urandom);
        b_br = 20'($urandom); b_mk = 20'hFFFFF;
        bus.out_ready_i     = 1'b0;
        bus.in_valid_i      = 1'b1;
        bus.clause_broken_i = a_br;
        bus.mask_bits_i     = a_mk;
        bus.cand_idx_i      = 2'd3;
        bus.last_i          = 1'b0;
        tick();
        bus.in_valid_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.out_valid_o) begin lat = c; break; end
        end
        bv0 = bus.break_value_o;
        ov0 = bus.clause_broken_o;
        if (lat !== 3 || bv0 !== 5'($countones(a_br & a_mk))) begin
            n_bad++;
            $display("FAIL bp_first got %0d lat %0d want %0d lat 3", bv0, lat, $countones(a_br & a_mk));
        end
        n_cmp++;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid_i = 1'b1;
            tick();
            if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_ctl[%0d] got v%0h r%0h want v1 r0", c, bus.out_valid_o, bus.in_ready_o);
            end
            n_cmp++;
            if (bus.break_value_o !== bv0 || bus.clause_broken_o !== ov0) begin
                n_bad++;
                $display("FAIL bp_hold_data[%0d] got %0h/%0h want %0h/%0h", c, bus.break_value_o, bus.clause_broken_o, bv0, ov0);
            end
            n_cmp++;
        end
        bus.in_valid_i      = 1'b1;
        bus.clause_broken_i = b_br;
        bus.mask_bits_i     = b_mk;
        bus.cand_idx_i      = 2'd0;
        bus.out_ready_i     = 1'b1;
        #1;
        if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0h want 1", bus.in_ready_o); end
        n_cmp++;
        tick();
        bus.in_valid_i = 1'b0;
        if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_handoff_valid got %0h want 0", bus.out_valid_o); end
        n_cmp++;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick();
            if (bus.out_valid_o) begin lat = c - 1; break; end
        end
        if (lat !== 3 || bus.break_value_o !== 5'($countones(b_br))) begin
            n_bad++;
            $display("FAIL bp_second got %0d lat %0d want %0d lat 3", bus.break_value_o, lat, $countones(b_br));
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_reset_midcount();
        int lat; logic [4:0] bv; logic [1:0] oi; logic [19:0] ov; logic mv;
        logic seen;
        logic [19:0] br;
        bus.in_valid_i      = 1'b1;
        bus.clause_broken_i = 20'hFFFFF;
        bus.mask_bits_i     = 20'hFFFFF;
        bus.cand_idx_i      = 2'd3;
        bus.last_i          = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        if (bus.out_valid_o !== 1'b0 || bus.break_value_o !== 5'd0 || bus.cand_idx_o !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_out got %0h/%0h/%0h want 0/0/0", bus.out_valid_o, bus.break_value_o, bus.cand_idx_o);
        end
        n_cmp++;
        if (bus.clause_broken_o !== 20'd0) begin n_bad++; $display("FAIL rst_mid_vec got %0h want 0", bus.clause_broken_o); end
        n_cmp++;
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.out_valid_o || bus.min_valid_o) seen = 1'b1;
        end
        if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ghost got %0h want 0", seen); end
        n_cmp++;
        br = 20'($urandom);
        run_txn(br, 20'hFFFFF, 2'd1, 1'b1, lat, bv, oi, ov, mv);
        if (lat !== 3 || bv !== 5'($countones(br))) begin
            n_bad++;
            $display("FAIL rst_mid_fresh got %0d lat %0d want %0d lat 3", bv, lat, $countones(br));
        end
        n_cmp++;
    endtask

    task automatic test_min_track();
        int lat; logic [4:0] bv; logic [1:0] oi; logic [19:0] ov; logic mv;
        int vals[4];
        int pulses, mn, mi, exp_p, exp_v, exp_i;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b == 0) vals = '{5, 2, 2, 7};
            else for (int i = 0; i < 4; i++) vals[i] = $urandom_range(20, 0);
            pulses = 0;
            mn = vals[0];
            mi = 0;
            for (int i = 1; i < 4; i++) if (vals[i] < mn) begin mn = vals[i]; mi = i; end
            for (int i = 0; i < 4; i++) begin
                run_txn(ones_vec(vals[i]), 20'hFFFFF, 2'(i), i == 3, lat, bv, oi, ov, mv);
                if (bv !== 5'(vals[i])) begin
                    n_bad++;
                    $display("FAIL min_b%0d_bv[%0d] got %0d want %0d", b, i, bv, vals[i]);
                end
                n_cmp++;
                if (mv) pulses++;
            end
`ifdef BV_MIN_TRACK_EN
            exp_p = 1; exp_v = mn; exp_i = mi;
`else
            exp_p = 0; exp_v = 0; exp_i = 0;
`endif
            if (pulses !== exp_p) begin n_bad++; $display("FAIL min_b%0d_pulses got %0d want %0d", b, pulses, exp_p); end
            n_cmp++;
            tick();
            if (bus.min_valid_o !== 1'b0) begin n_bad++; $display("FAIL min_b%0d_pulse_len got %0h want 0", b, bus.min_valid_o); end
            n_cmp++;
            if (bus.min_value_o !== 5'(exp_v) || bus.min_idx_o !== 2'(exp_i)) begin
                n_bad++;
                $display("FAIL min_b%0d_result got %0d@%0d want %0d@%0d", b, bus.min_value_o, bus.min_idx_o, exp_v, exp_i);
            end
            n_cmp++;
        end
    endtask

    task automatic test_small_cfg();
        logic [8:0] br, mk;
        int lat;
        for (int t = 0; t < 8; t++) begin
            br = (t == 0) ? 9'h1FF : 9'($urandom);
            mk = (t == 0) ? 9'h1FF : 9'($urandom);
            sbus.in_valid_i      = 1'b1;
            sbus.clause_broken_i = br;
            sbus.mask_bits_i     = mk;
            sbus.cand_idx_i      = 2'(t);
            tick();
            sbus.in_valid_i      = 1'b0;
            sbus.clause_broken_i = 9'($urandom);
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (sbus.out_valid_o) begin lat = c; break; end
            end
            if (lat !== 3 || sbus.break_value_o !== 4'($countones(br & mk))) begin
                n_bad++;
                $display("FAIL small_bv[%0d] got %0d lat %0d want %0d lat 3", t, sbus.break_value_o, lat, $countones(br & mk));
            end
            n_cmp++;
            if (sbus.clause_broken_o !== (br & mk)) begin
                n_bad++;
                $display("FAIL small_vec[%0d] got %0h want %0h", t, sbus.clause_broken_o, br & mk);
            end
            n_cmp++;
            tick();
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus.in_valid_i      = 1'b0;
        bus.clause_broken_i = '0;
        bus.mask_bits_i     = '0;
        bus.cand_idx_i      = '0;
        bus.last_i          = 1'b0;
        bus.out_ready_i     = 1'b1;
        sbus.in_valid_i      = 1'b0;
        sbus.clause_broken_i = '0;
        sbus.mask_bits_i     = '0;
        sbus.cand_idx_i      = '0;
        sbus.last_i          = 1'b0;
        sbus.out_ready_i     = 1'b1;
        test_reset();
        test_all_broken();
        test_masked();
        test_random();
        test_backpressure();
        test_reset_midcount();
        test_min_track();
        test_small_cfg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
